// File: rtl/gate_vec_pkg.sv
// Shared types and truth-table constants for the gate-vector sequencer.
// Truth tables index the input vector {a,b,c}; bit i is the expected gate output for vector i.
package gate_vec_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StSettle,
    StCheck,
    StDone
  } gate_vec_state_e;

  localparam logic [7:0] TRUTH_AOI21 = 8'h15;  // ~((a & b) | c)
  localparam logic [7:0] TRUTH_OAI21 = 8'h57;  // ~((a | b) & c)
  localparam logic [7:0] TRUTH_NAND3 = 8'h7f;
  localparam logic [7:0] TRUTH_NOR3  = 8'h01;

endpackage

// File: rtl/gate_vec_settle_cnt.sv
// Settle-delay counter: loads a count, decrements on request, flags zero.
module gate_vec_settle_cnt #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - {{(Width-1){1'b0}}, 1'b1};
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gate_vec_seq.sv
// Exhaustive combinational-gate tester: sweeps all input vectors, compares y_i to TRUTH.
// Optional first-mismatch capture is built when GATE_VEC_SEQ_FIRST_ERR_EN is defined.
module gate_vec_seq
  import gate_vec_pkg::*;
#(
  parameter int unsigned              N_IN       = 3,
  parameter logic [(1 << N_IN) - 1:0] TRUTH      = TRUTH_AOI21,
  parameter int unsigned              SETTLE_CYC = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            y_i,
  output logic [N_IN-1:0] vec_o,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_err_vec
);

  localparam logic [N_IN-1:0] VecMax     = '1;
  localparam logic [N_IN-1:0] VecOne     = {{(N_IN-1){1'b0}}, 1'b1};
  localparam logic [N_IN:0]   ErrOne     = {{N_IN{1'b0}}, 1'b1};
  // Counter is preloaded with SETTLE_CYC-1 so SETTLE lasts exactly SETTLE_CYC cycles.
  localparam logic [3:0]      SettleLoad = (SETTLE_CYC > 0) ? 4'(SETTLE_CYC - 1) : 4'd0;

  gate_vec_state_e state_q, state_d;

  logic [N_IN-1:0] vec_q;
  logic [N_IN:0]   err_q;
  logic            busy_q;
  logic            pass_q;
  logic            settle_zero;
  logic            mismatch;

  assign mismatch = (state_q == StCheck) && (y_i != TRUTH[vec_q]);

  gate_vec_settle_cnt #(
    .Width (4)
  ) u_settle_cnt (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (state_q == StDrive),
    .load_val_i (SettleLoad),
    .dec_i      (state_q == StSettle),
    .zero_o     (settle_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StDrive;
      StDrive:  state_d = (SETTLE_CYC == 0) ? StCheck : StSettle;
      StSettle: if (settle_zero) state_d = StCheck;
      StCheck:  state_d = (vec_q == VecMax) ? StDone : StDrive;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    done = (state_q == StDone);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec_q  <= '0;
      err_q  <= '0;
      busy_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      if ((state_q == StIdle) && start) begin
        vec_q  <= '0;
        err_q  <= '0;
        pass_q <= 1'b0;
        busy_q <= 1'b1;
      end
      if (state_q == StCheck) begin
        if (mismatch) err_q <= err_q + ErrOne;
        if (vec_q != VecMax) vec_q <= vec_q + VecOne;
      end
      if (state_q == StDone) begin
        pass_q <= (err_q == '0);
        busy_q <= 1'b0;
      end
    end
  end

`ifdef GATE_VEC_SEQ_FIRST_ERR_EN
  logic [N_IN-1:0] first_err_q;

  // err_q is still zero on the first mismatching CHECK of a sweep.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first_err_q <= '0;
    end else if ((state_q == StIdle) && start) begin
      first_err_q <= '0;
    end else if (mismatch && (err_q == '0)) begin
      first_err_q <= vec_q;
    end
  end

  assign first_err_vec = first_err_q;
`else
  assign first_err_vec = '0;
`endif

  assign vec_o   = vec_q;
  assign busy    = busy_q;
  assign pass    = pass_q;
  assign err_cnt = err_q;

endmodule

// File: doc/gate_vec_seq.md
GATE_VEC_SEQ -- requirements
Module: gate_vec_seq

Interface
REQ-001 Parameter N_IN, default 3, number of gate inputs driven (1..6).
REQ-002 Parameter TRUTH, default 8'h15, expected-output truth table of width 2**N_IN; bit i = expected y for input vector i (8'h15 = AOI21, y = ~((a&b)|c), vector = {a,b,c}).
REQ-003 Parameter SETTLE_CYC, default 2, number of wait cycles between driving a vector and sampling y (0..15).
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin an exhaustive sweep.
REQ-007 y_i  input  1  output of the gate under test.
REQ-008 vec_o  output  N_IN  stimulus vector driving the gate inputs, MSB = first gate input.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  one-cycle pulse when the sweep completes.
REQ-011 pass  output  1  high when the last completed sweep had zero mismatches.
REQ-012 err_cnt  output  N_IN+1  mismatch count of the current or last sweep.
REQ-013 first_err_vec  output  N_IN  first mismatching vector (see Configuration).

Function
REQ-014 FSM states IDLE, DRIVE, SETTLE, CHECK, DONE, encoded as a package enum.
REQ-015 IDLE: start=1 -> DRIVE next cycle; vec_o<=0, err_cnt<=0, pass<=0, busy<=1.
REQ-016 DRIVE: lasts 1 cycle; vec_o holds current vector -> SETTLE (or CHECK if SETTLE_CYC=0).
REQ-017 SETTLE: lasts exactly SETTLE_CYC cycles, counted by a settle counter -> CHECK.
REQ-018 CHECK: sample y_i once; if y_i != TRUTH[vec_o], increment err_cnt.
REQ-019 CHECK with vec_o != 2**N_IN-1: vec_o<=vec_o+1 -> DRIVE; with vec_o == 2**N_IN-1: -> DONE, vec_o holds.
REQ-020 DONE: done=1 for exactly one cycle; pass<=(final err_cnt==0); busy<=0 -> IDLE.
REQ-021 Per-vector period = SETTLE_CYC+2 cycles; done asserts (SETTLE_CYC+2)*2**N_IN+1 cycles after the start cycle (default: cycle 33).
REQ-022 vec_o changes only on DRIVE entry; it is stable throughout SETTLE and CHECK.
REQ-023 start while busy=1 is ignored; start in the DONE cycle is ignored.
REQ-024 err_cnt cannot overflow: maximum value 2**N_IN fits in N_IN+1 bits.
REQ-025 err_cnt, pass, and first_err_vec hold their values in IDLE until the next accepted start.

Reset
REQ-026 rst_n=0 at a clock edge: state<=IDLE, vec_o<=0, busy<=0, done<=0, pass<=0, err_cnt<=0, first_err_vec<=0, settle counter<=0.
REQ-027 Reset mid-sweep aborts the sweep; no done pulse is produced; the next start begins again at vector 0.

Configuration
REQ-028 Macro GATE_VEC_SEQ_FIRST_ERR_EN defined: on the first mismatch of a sweep, first_err_vec<=vec_o; later mismatches leave it unchanged; the register clears on an accepted start.
REQ-029 Macro undefined: first_err_vec is tied to 0 and no capture register is built.

Structure
REQ-030 Package gate_vec_pkg holds the FSM state enum, the TRUTH_AOI21=8'h15 constant, and the OAI21/NAND3/NOR3 truth constants.
REQ-031 The settle counter is a sub-module gate_vec_settle_cnt (load, count-down, zero flag); all remaining logic lives in gate_vec_seq.

Verification
REQ-032 Default parameters, bench AOI21 model on y_i, pulse start -> vec_o steps 0..7 every 4 cycles; done at cycle 33; pass=1; err_cnt=0.
REQ-033 y_i stuck at 0 -> err_cnt=3, pass=0, first_err_vec=3'b000 (with macro defined).
REQ-034 y_i stuck at 1 -> err_cnt=5, pass=0, first_err_vec=3'b001 (with macro defined); first_err_vec=0 with macro undefined.
REQ-035 rst_n=0 for 1 cycle while vec_o=4 -> next cycle state IDLE, vec_o=0, busy=0, err_cnt=0; no done pulse; a fresh start then completes with pass=1.
REQ-036 start held high for the whole sweep, plus a start pulse during SETTLE -> exactly one sweep and one done pulse.
REQ-037 SETTLE_CYC=0 -> per-vector period is 2 cycles; done at cycle 17; pass=1 with a correct AOI21 model.
